// File: rtl/tea_lane_scheduler_if.sv
// Ciphertext-in / plaintext-out handshakes of the
// round-robin TEA lane scheduler.
interface tea_lane_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;

  modport master (
    output in_valid,
    output in_block,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_block
  );

  modport slave (
    input  in_valid,
    input  in_block,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_block
  );
endinterface

// File: rtl/tea_lane_scheduler.sv
// Round-robin scheduler over LANES iterative TEA
// decryption lanes; in-order fill and drain.
module tea_lane_scheduler #(
  parameter int          LANES  = 8,
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [127:0]        key,
  tea_lane_scheduler_if.slave io,
  output logic [LANES-1:0]    lanes_busy
);

  localparam int PW =
    (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [31:0] SUM0 =
    32'(DELTA * 32'(ROUNDS));
  localparam logic [5:0] CNT0 =
    6'(ROUNDS - 1);
  localparam logic [PW-1:0] LAST =
    PW'(LANES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [1:0]    w_st [LANES];
  logic [63:0]   w_pt [LANES];
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_acc;
  logic          w_xfer;

  function automatic logic [63:0] round_f(
    input logic [31:0]  v0,
    input logic [31:0]  v1,
    input logic [31:0]  sum,
    input logic [127:0] k
  );
    logic [31:0] n1;
    logic [31:0] n0;
    n1 = v1 - (((v0 << 4) + k[63:32])
             ^ (v0 + sum)
             ^ ((v0 >> 5) + k[31:0]));
    n0 = v0 - (((n1 << 4) + k[127:96])
             ^ (n1 + sum)
             ^ ((n1 >> 5) + k[95:64]));
    return {n0, n1};
  endfunction

  assign w_in_ready  = ena
                     & (w_st[r_wr] == S_IDLE);
  assign w_out_valid = ena
                     & (w_st[r_rd] == S_DONE);
  assign w_acc  = io.in_valid & w_in_ready;
  assign w_xfer = io.out_ready & w_out_valid;

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = w_out_valid;
  assign io.out_block = w_out_valid
                      ? w_pt[r_rd] : 64'h0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [1:0]   r_st;
    logic [31:0]  r_v0;
    logic [31:0]  r_v1;
    logic [31:0]  r_sum;
    logic [127:0] r_key;
    logic [5:0]   r_cnt;
    logic         w_sel_wr;
    logic         w_sel_rd;
    logic [63:0]  w_nxt;

    assign w_sel_wr = (r_wr == PW'(g));
    assign w_sel_rd = (r_rd == PW'(g));
    assign w_nxt = round_f(r_v0, r_v1,
                           r_sum, r_key);
    assign w_st[g] = r_st;
    assign w_pt[g] = {r_v0, r_v1};
    assign lanes_busy[g] = (r_st != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st  <= S_IDLE;
        r_v0  <= '0;
        r_v1  <= '0;
        r_sum <= '0;
        r_key <= '0;
        r_cnt <= '0;
      end else if (ena) begin
        unique case (r_st)
          S_IDLE: begin
            if (w_acc && w_sel_wr) begin
              r_v0  <= io.in_block[63:32];
              r_v1  <= io.in_block[31:0];
              r_key <= key;
              r_sum <= SUM0;
              r_cnt <= CNT0;
              r_st  <= S_RUN;
            end
          end
          S_RUN: begin
            r_v0  <= w_nxt[63:32];
            r_v1  <= w_nxt[31:0];
            r_sum <= r_sum - DELTA;
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd0)
              r_st <= S_DONE;
          end
          S_DONE: begin
            if (w_xfer && w_sel_rd)
              r_st <= S_IDLE;
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  // Pointers only move on handshakes, which already imply ena.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_acc)
        r_wr <= (r_wr == LAST) ? '0
              : r_wr + 1'b1;
      if (w_xfer)
        r_rd <= (r_rd == LAST) ? '0
              : r_rd + 1'b1;
    end
  end

endmodule

// File: tb/tb_tea_lane_scheduler.sv
// Bench for tea_lane_scheduler: three parameter sets,
// queue-based reference model, directed + random traffic.
module tb_tea_lane_scheduler;

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [63:0] VEC = 64'h41EA3A0A94BAA940;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic [127:0] key = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [63:0]  in_block = '0;
  int           sel = 0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  tea_lane_scheduler_if if0 ();
  tea_lane_scheduler_if if1 ();
  tea_lane_scheduler_if if2 ();
  logic [7:0] busy0;
  logic [0:0] busy1;
  logic [2:0] busy2;

  assign if0.in_valid  = in_valid && sel == 0;
  assign if1.in_valid  = in_valid && sel == 1;
  assign if2.in_valid  = in_valid && sel == 2;
  assign if0.out_ready = out_ready && sel == 0;
  assign if1.out_ready = out_ready && sel == 1;
  assign if2.out_ready = out_ready && sel == 2;
  assign if0.in_block  = in_block;
  assign if1.in_block  = in_block;
  assign if2.in_block  = in_block;

  tea_lane_scheduler #(.LANES(8), .ROUNDS(32)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .key(key),
    .io(if0), .lanes_busy(busy0));
  tea_lane_scheduler #(.LANES(1), .ROUNDS(32)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .key(key),
    .io(if1), .lanes_busy(busy1));
  tea_lane_scheduler #(.LANES(3), .ROUNDS(16)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .key(key),
    .io(if2), .lanes_busy(busy2));

  logic        o_rdy;
  logic        o_vld;
  logic [63:0] o_blk;
  logic [15:0] o_busy;

  always_comb begin
    o_rdy  = if0.in_ready;
    o_vld  = if0.out_valid;
    o_blk  = if0.out_block;
    o_busy = {8'h0, busy0};
    if (sel == 1) begin
      o_rdy  = if1.in_ready;
      o_vld  = if1.out_valid;
      o_blk  = if1.out_block;
      o_busy = {15'h0, busy1};
    end else if (sel == 2) begin
      o_rdy  = if2.in_ready;
      o_vld  = if2.out_valid;
      o_blk  = if2.out_block;
      o_busy = {13'h0, busy2};
    end
  end

  function automatic int nl(input int s);
    return (s == 0) ? 8 : (s == 1) ? 1 : 3;
  endfunction

  function automatic int nr(input int s);
    return (s == 2) ? 16 : 32;
  endfunction

  // Textbook TEA decryption of one block.
  function automatic logic [63:0] tea_dec(
    input logic [63:0] b, input logic [127:0] k,
    input int n);
    logic [31:0] v0, v1, s;
    logic [31:0] k0, k1, k2, k3;
    v0 = b[63:32]; v1 = b[31:0];
    k0 = k[127:96]; k1 = k[95:64];
    k2 = k[63:32];  k3 = k[31:0];
    s = 32'(DELTA * 32'(n));
    for (int i = 0; i < n; i++) begin
      v1 -= ((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3);
      v0 -= ((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1);
      s -= DELTA;
    end
    return {v0, v1};
  endfunction

  // In-flight blocks in acceptance order; age counts enabled edges.
  typedef struct {
    logic [63:0] exp;
    int          age;
  } item_t;
  item_t q[$];
  int    m_rd = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_busy();
    logic [63:0] b;
    int L;
    b = '0;
    L = nl(sel);
    for (int i = 0; i < q.size(); i++)
      b[(m_rd + i) % L] = 1'b1;
    return b;
  endfunction

  task automatic cycle();
    int L, R;
    logic er, ev;
    logic [63:0] eb, e;
    bit acc, xf;
    L = nl(sel);
    R = nr(sel);
    er = ena && (q.size() < L);
    ev = ena && (q.size() > 0) && (q[0].age >= R);
    eb = ev ? q[0].exp : 64'h0;
    #1;
    chk("in_ready", 64'(o_rdy), 64'(er));
    chk("out_valid", 64'(o_vld), 64'(ev));
    chk("out_block", o_blk, eb);
    chk("lanes_busy", 64'(o_busy), exp_busy());
    acc = in_valid && er;
    xf = out_ready && ev;
    e = tea_dec(in_block, key, R);
    @(posedge clk);
    if (ena) begin
      if (xf) begin
        void'(q.pop_front());
        m_rd = (m_rd + 1) % L;
      end
      foreach (q[i])
        if (q[i].age < R) q[i].age++;
      if (acc) q.push_back('{exp: e, age: 0});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_vld", 64'(o_vld), 64'h0);
    chk("rst_blk", o_blk, 64'h0);
    chk("rst_rdy", 64'(o_rdy), 64'(ena));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_rd = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    #1;
    while (!o_vld && n < 300) begin
      cycle();
      n++;
      #1;
    end
    if (!o_vld) begin
      total++;
      bad++;
      $error("FAIL wait_valid observed=0 expected=1");
    end
  endtask

  task automatic drain();
    int k;
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 400) begin
      cycle();
      k++;
    end
    cycle();
    #1;
    chk("drain_busy", 64'(o_busy), 64'h0);
  endtask

  task automatic single();
    int n, R;
    R = nr(sel);
    ena = 1'b1; key = '0; out_ready = 1'b1;
    in_block = VEC; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    wait_valid(n);
    chk("single_lat", 64'(n), 64'(R));
    chk("single_pt", o_blk,
        (R == 32) ? 64'h0 : tea_dec(VEC, '0, R));
    cycle();
    #1;
    chk("single_once", 64'(o_vld), 64'h0);
  endtask

  task automatic stall();
    int n, R;
    logic [63:0] b;
    logic [127:0] k;
    R = nr(sel);
    b = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    ena = 1'b1; key = k; in_block = b;
    out_ready = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    ena = 1'b0;
    repeat (10) cycle();
    ena = 1'b1;
    wait_valid(n);
    chk("stall_lat", 64'(n + 13), 64'(R + 10));
    chk("stall_pt", o_blk, tea_dec(b, k, R));
    cycle();
  endtask

  task automatic burst();
    int R;
    R = nr(sel);
    ena = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2 * (R + 2); i++) begin
      in_block = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    drain();
  endtask

  task automatic backpressure();
    int L, R;
    logic [63:0] m;
    L = nl(sel);
    R = nr(sel);
    m = (64'h1 << L) - 64'h1;
    ena = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < L; i++) begin
      in_block = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    repeat (R + 4) cycle();
    #1;
    chk("bp_busy", 64'(o_busy), m);
    chk("bp_rdy", 64'(o_rdy), 64'h0);
    out_ready = 1'b1;
    repeat (L + 2) cycle();
    #1;
    chk("bp_empty", 64'(o_busy), 64'h0);
  endtask

  task automatic key_indep();
    int n, R;
    logic [63:0] b;
    logic [127:0] k1;
    R = nr(sel);
    b = {$urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    ena = 1'b1; out_ready = 1'b1;
    key = k1; in_block = b; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    key = ~k1;
    wait_valid(n);
    chk("key_indep", o_blk, tea_dec(b, k1, R));
    cycle();
  endtask

  task automatic mid_reset();
    ena = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      in_block = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    do_reset();
    single();
  endtask

  task automatic random_run();
    repeat (300) begin
      ena = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_block = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    drain();
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      sel = s;
      ena = 1'b1;
      do_reset();
      single();
      stall();
      burst();
      backpressure();
      key_indep();
      mid_reset();
      random_run();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
